// File: rtl/v_mul_pipe_if.sv
// Beat bundle for v_mul_pipe: packed lane operands with sew/mode in, packed lane results out.
// A beat moves when valid && ready at a rising edge; a source holds its beat while ready is low.
interface v_mul_pipe_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   op_A;
    logic [32*LANES-1:0]   op_B;
    logic [1:0]            sew;
    logic [1:0]            mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   result;
    logic                  illegal;

    modport master (
        output in_valid, op_A, op_B, sew, mode, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, op_A, op_B, sew, mode, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/v_mul_pipe.sv
// Three-stage vector integer multiplier: per lane four 17x17 signed multipliers serve four byte
// products, two halfword products, or the four partial products of one 32-bit product.
module v_mul_pipe #(
    parameter int LANES = 4,
    parameter int LAT   = 3
) (
    input  logic        clk,
    input  logic        nrst,
    v_mul_pipe_if.slave bus
);
    localparam int W = 32 * LANES;

    logic           w_adv;
    logic [LAT-1:0] r_vld;
    logic           w_a_sgn;
    logic           w_b_sgn;
    logic [16:0]    w_a  [LANES][4];
    logic [16:0]    w_b  [LANES][4];
    logic [16:0]    r_a1 [LANES][4];
    logic [16:0]    r_b1 [LANES][4];
    logic [1:0]     r_sew1, r_mode1, r_sew2, r_mode2;
    logic [33:0]    r_p2 [LANES][4];
    logic [63:0]    w_full [LANES];
    logic           w_hi;
    logic [W-1:0]   w_res;
    logic [W-1:0]   r_result;
    logic           r_illegal;

    function automatic logic [16:0] ext8(input logic [7:0] v, input logic s);
        return {{9{s & v[7]}}, v};
    endfunction

    function automatic logic [16:0] ext16(input logic [15:0] v, input logic s);
        return {s & v[15], v};
    endfunction

    // Whole pipe shifts as one; bubbles are kept so latency stays fixed.
    assign w_adv         = !r_vld[LAT-1] || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[LAT-1];
    assign bus.result    = r_result;
    assign bus.illegal   = r_illegal;

    always_comb begin
        w_a_sgn = bus.mode[0];
        w_b_sgn = (bus.mode == 2'b01);
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 4; k++) begin
                w_a[l][k] = '0;
                w_b[l][k] = '0;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            case (bus.sew)
                2'b00: begin
                    for (int k = 0; k < 4; k++) begin
                        w_a[l][k] = ext8(bus.op_A[32*l+8*k +: 8], w_a_sgn);
                        w_b[l][k] = ext8(bus.op_B[32*l+8*k +: 8], w_b_sgn);
                    end
                end
                2'b01: begin
                    w_a[l][0] = ext16(bus.op_A[32*l    +: 16], w_a_sgn);
                    w_b[l][0] = ext16(bus.op_B[32*l    +: 16], w_b_sgn);
                    w_a[l][3] = ext16(bus.op_A[32*l+16 +: 16], w_a_sgn);
                    w_b[l][3] = ext16(bus.op_B[32*l+16 +: 16], w_b_sgn);
                end
                2'b10: begin
                    // Low halves are magnitude-only; the sign lives in the high halves.
                    w_a[l][0] = ext16(bus.op_A[32*l    +: 16], 1'b0);
                    w_b[l][0] = ext16(bus.op_B[32*l    +: 16], 1'b0);
                    w_a[l][1] = ext16(bus.op_A[32*l    +: 16], 1'b0);
                    w_b[l][1] = ext16(bus.op_B[32*l+16 +: 16], w_b_sgn);
                    w_a[l][2] = ext16(bus.op_A[32*l+16 +: 16], w_a_sgn);
                    w_b[l][2] = ext16(bus.op_B[32*l    +: 16], 1'b0);
                    w_a[l][3] = ext16(bus.op_A[32*l+16 +: 16], w_a_sgn);
                    w_b[l][3] = ext16(bus.op_B[32*l+16 +: 16], w_b_sgn);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_hi  = (r_mode2 != 2'b00);
        w_res = '0;
        for (int l = 0; l < LANES; l++) begin
            w_full[l] = {{30{r_p2[l][0][33]}}, r_p2[l][0]}
                      + ({{30{r_p2[l][1][33]}}, r_p2[l][1]} << 16)
                      + ({{30{r_p2[l][2][33]}}, r_p2[l][2]} << 16)
                      + ({{30{r_p2[l][3][33]}}, r_p2[l][3]} << 32);
        end
        for (int l = 0; l < LANES; l++) begin
            case (r_sew2)
                2'b00: begin
                    for (int k = 0; k < 4; k++) begin
                        w_res[32*l+8*k +: 8] = w_hi ? r_p2[l][k][15:8] : r_p2[l][k][7:0];
                    end
                end
                2'b01: begin
                    w_res[32*l    +: 16] = w_hi ? r_p2[l][0][31:16] : r_p2[l][0][15:0];
                    w_res[32*l+16 +: 16] = w_hi ? r_p2[l][3][31:16] : r_p2[l][3][15:0];
                end
                2'b10: w_res[32*l +: 32] = w_hi ? w_full[l][63:32] : w_full[l][31:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld     <= '0;
            r_sew1    <= '0;
            r_mode1   <= '0;
            r_sew2    <= '0;
            r_mode2   <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                for (int k = 0; k < 4; k++) begin
                    r_a1[l][k] <= '0;
                    r_b1[l][k] <= '0;
                    r_p2[l][k] <= '0;
                end
            end
        end else if (w_adv) begin
            r_vld   <= {r_vld[LAT-2:0], bus.in_valid};
            r_sew1  <= bus.sew;
            r_mode1 <= bus.mode;
            r_sew2  <= r_sew1;
            r_mode2 <= r_mode1;
            for (int l = 0; l < LANES; l++) begin
                for (int k = 0; k < 4; k++) begin
                    r_a1[l][k] <= w_a[l][k];
                    r_b1[l][k] <= w_b[l][k];
                    r_p2[l][k] <= $signed({{17{r_a1[l][k][16]}}, r_a1[l][k]})
                                * $signed({{17{r_b1[l][k][16]}}, r_b1[l][k]});
                end
            end
            // Bubbles and reserved-sew beats leave zeros on the result bus.
            r_result  <= r_vld[LAT-2] ? w_res : '0;
            r_illegal <= r_vld[LAT-2] && (r_sew2 == 2'b11);
        end
    end
endmodule

// File: tb/tb_v_mul_pipe.sv
// Bench for v_mul_pipe: directed products, back-to-back mixed beats, backpressure, random stream, reset.
module tb_v_mul_pipe;
    localparam int LANES = 4;
    localparam int W     = 32 * LANES;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    v_mul_pipe_if #(.LANES(LANES)) bus();

    v_mul_pipe #(.LANES(LANES), .LAT(3)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each element is a plain integer product, signedness from mode.
    function automatic logic [W:0] model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] sew, input logic [1:0] mode);
        logic [W-1:0]        res;
        logic signed [127:0] pa, pb, pr;
        logic [127:0]        mask, val;
        int                  s;
        bit                  sa, sb;
        if (sew == 2'b11) return {1'b1, {W{1'b0}}};
        s    = 8 << sew;
        mask = (128'd1 << s) - 128'd1;
        sa   = (mode == 2'b01) || (mode == 2'b11);
        sb   = (mode == 2'b01);
        res  = '0;
        for (int off = 0; off < W; off += s) begin
            pa = 128'(a >> off) & mask;
            pb = 128'(b >> off) & mask;
            if (sa && pa[s-1]) pa = pa - (mask + 128'd1);
            if (sb && pb[s-1]) pb = pb - (mask + 128'd1);
            pr  = pa * pb;
            val = (mode == 2'b00) ? (pr & mask) : ((pr >>> s) & mask);
            res = res | W'(val << off);
        end
        return {1'b0, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0;
        bus.op_A     = '0;
        bus.op_B     = '0;
        bus.sew      = 2'b00;
        bus.mode     = 2'b00;
    endtask

    task automatic drive_beat(input logic [1:0] sew, input logic [1:0] mode);
        bus.in_valid = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            bus.op_A[32*l +: 32] = $urandom();
            bus.op_B[32*l +: 32] = $urandom();
        end
        bus.sew  = sew;
        bus.mode = mode;
    endtask

    task automatic test_reset();
        nrst          = 1'b0;
        bus.out_ready = 1'b0;
        set_idle();
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", bus.result);
        end
        n_checks++;
        if (bus.illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal);
        end
        #10;
        nrst = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_a [11];
        logic [31:0] d_b [11];
        logic [1:0]  d_sew [11];
        logic [1:0]  d_mode [11];
        logic [31:0] d_exp [11];
        logic        d_ill [11];
        int          lat;
        d_a[0]  = 32'h80000000; d_b[0]  = 32'h80000000; d_sew[0]  = 2; d_mode[0]  = 1; d_exp[0]  = 32'h40000000;
        d_a[1]  = 32'h80000000; d_b[1]  = 32'h80000000; d_sew[1]  = 2; d_mode[1]  = 0; d_exp[1]  = 32'h00000000;
        d_a[2]  = 32'hFFFFFFFF; d_b[2]  = 32'hFFFFFFFF; d_sew[2]  = 2; d_mode[2]  = 3; d_exp[2]  = 32'hFFFFFFFF;
        d_a[3]  = 32'hFFFFFFFF; d_b[3]  = 32'hFFFFFFFF; d_sew[3]  = 2; d_mode[3]  = 2; d_exp[3]  = 32'hFFFFFFFE;
        d_a[4]  = 32'h7F80FF02; d_b[4]  = 32'h02020303; d_sew[4]  = 0; d_mode[4]  = 0; d_exp[4]  = 32'hFE00FD06;
        d_a[5]  = 32'h7F80FF02; d_b[5]  = 32'h02020303; d_sew[5]  = 0; d_mode[5]  = 1; d_exp[5]  = 32'h00FFFF00;
        d_a[6]  = 32'h7F80FF02; d_b[6]  = 32'h02020303; d_sew[6]  = 0; d_mode[6]  = 2; d_exp[6]  = 32'h00010200;
        d_a[7]  = 32'h8000FFFF; d_b[7]  = 32'h80000002; d_sew[7]  = 1; d_mode[7]  = 1; d_exp[7]  = 32'h4000FFFF;
        d_a[8]  = 32'h8000FFFF; d_b[8]  = 32'h80000002; d_sew[8]  = 1; d_mode[8]  = 2; d_exp[8]  = 32'h40000001;
        d_a[9]  = 32'h8000FFFF; d_b[9]  = 32'h80000002; d_sew[9]  = 1; d_mode[9]  = 0; d_exp[9]  = 32'h0000FFFE;
        d_a[10] = 32'h12345678; d_b[10] = 32'h9ABCDEF0; d_sew[10] = 3; d_mode[10] = 1; d_exp[10] = 32'h00000000;
        for (int i = 0; i < 11; i++) d_ill[i] = (i == 10);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.op_A     = {LANES{d_a[i]}};
            bus.op_B     = {LANES{d_b[i]}};
            bus.sew      = d_sew[i];
            bus.mode     = d_mode[i];
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            tick();
            set_idle();
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 8) begin
                tick();
                lat++;
            end
            n_checks++;
            if (lat != 3) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d cycles want 3", i, lat);
            end
            n_checks++;
            if (bus.result !== {LANES{d_exp[i]}}) begin
                n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, bus.result, {LANES{d_exp[i]}});
            end
            n_checks++;
            if (bus.illegal !== d_ill[i]) begin
                n_fail++; $display("FAIL dir%0d_illegal: got %b want %b", i, bus.illegal, d_ill[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] s_seq [10];
        logic [1:0] m_seq [10];
        logic [W:0] exp;
        int sent = 0, pops = 0;
        bit first = 0;
        s_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
        m_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3};
        exp_q.delete();
        for (int c = 0; c < 40 && pops < 10; c++) begin
            tick();
            if (sent < 10) drive_beat(s_seq[sent], m_seq[sent]);
            else set_idle();
            bus.out_ready = 1'b1;
            #1;
            if (first && pops < 10) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_gap: out_valid got %b want 1 after %0d results", bus.out_valid, pops);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                first = 1;
                pops++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %h with nothing expected", bus.result);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.illegal, bus.result} !== exp) begin
                        n_fail++; $display("FAIL b2b_result: got %h want %h", {bus.illegal, bus.result}, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_beat(bus.op_A, bus.op_B, bus.sew, bus.mode));
                sent++;
            end
        end
        n_checks++;
        if (pops != 10 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results (%0d left) want 10", pops, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W:0]   exp;
        logic [W-1:0] res_prev = '0;
        logic         ill_prev = 1'b0;
        bit stall_prev = 0, stall_now, acc = 1;
        int sent = 0, pops = 0, c = 0;
        exp_q.delete();
        set_idle();
        while ((sent < 8 || exp_q.size() > 0) && c < 100) begin
            tick();
            if (stall_prev) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.result !== res_prev || bus.illegal !== ill_prev) begin
                    n_fail++; $display("FAIL bp_stable: got v=%b r=%h i=%b want v=1 r=%h i=%b",
                                       bus.out_valid, bus.result, bus.illegal, res_prev, ill_prev);
                end
            end
            if (acc || !bus.in_valid) begin
                if (sent < 8) drive_beat(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                else set_idle();
            end
            bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            stall_now = bus.out_valid && !bus.out_ready;
            n_checks++;
            if (bus.in_ready !== !stall_now) begin
                n_fail++; $display("FAIL bp_in_ready: got %b want %b", bus.in_ready, !stall_now);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got %h with nothing expected", bus.result);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.illegal, bus.result} !== exp) begin
                        n_fail++; $display("FAIL bp_result: got %h want %h", {bus.illegal, bus.result}, exp);
                    end
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                exp_q.push_back(model_beat(bus.op_A, bus.op_B, bus.sew, bus.mode));
                sent++;
            end
            stall_prev = stall_now;
            res_prev   = bus.result;
            ill_prev   = bus.illegal;
            c++;
        end
        n_checks++;
        if (pops != 8 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d results (%0d left) want 8", pops, exp_q.size());
        end
    endtask

    task automatic test_random_stream();
        logic [W:0] exp;
        bit acc = 1;
        exp_q.delete();
        set_idle();
        for (int c = 0; c < 320; c++) begin
            tick();
            if (c >= 300) begin
                set_idle();
                bus.out_ready = 1'b1;
            end else begin
                if (acc || !bus.in_valid) begin
                    if ($urandom_range(0, 9) < 7) drive_beat(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                    else set_idle();
                end
                bus.out_ready = ($urandom_range(0, 9) < 7);
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: got %h with nothing expected", bus.result);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.illegal, bus.result} !== exp) begin
                        n_fail++; $display("FAIL rnd_result: got %h want %h", {bus.illegal, bus.result}, exp);
                    end
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) exp_q.push_back(model_beat(bus.op_A, bus.op_B, bus.sew, bus.mode));
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain: got %0d results outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_beat(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
        end
        tick();
        set_idle();
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.illegal !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_clear: got v=%b r=%h i=%b want all 0", bus.out_valid, bus.result, bus.illegal);
        end
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.result !== '0) begin
                n_fail++; $display("FAIL mid_stale_%0d: got v=%b r=%h want v=0 r=0", c, bus.out_valid, bus.result);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
